// File: rtl/seq_approx_divider.sv
// Sequential restoring divider producing one quotient bit per cycle, MSB first.
// The low APPROX_ROWS rows can optionally skip the subtraction and guess the bit instead.
module seq_approx_divider #(
    parameter int unsigned W           = 8,
    parameter int unsigned APPROX_ROWS = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned KW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2*W-1:0]  n_r;
    logic [W-1:0]    d_r;
    logic            approx_r;
    logic [KW-1:0]   k;

    logic [W-1:0]    n_low;
    logic [W-1:0]    lo_c;
    logic            top_c;
    logic [W:0]      diff_c;
    logic            approx_row_c;
    logic            q_bit_c;
    logic [W-1:0]    r_nxt_c;

    assign n_low = n_r[W-1:0];

    // Row window, exact subtract-and-compare, and the approximate guess.
    always_comb begin
        lo_c         = '0;
        top_c        = 1'b0;
        diff_c       = '0;
        approx_row_c = 1'b0;
        q_bit_c      = 1'b0;
        r_nxt_c      = '0;
        if (k == KW'(W - 1)) begin
            lo_c  = n_r[2*W-2:W-1];
            top_c = n_r[2*W-1];
        end else begin
            lo_c  = {remainder[W-2:0], n_low[k]};
            top_c = remainder[W-1];
        end
        diff_c       = {1'b0, lo_c} - {1'b0, d_r};
        approx_row_c = approx_r && ((32'(k) + 32'd1) <= APPROX_ROWS);
        if (approx_row_c) begin
            q_bit_c = top_c | lo_c[W-1];
            r_nxt_c = lo_c;
        end else begin
            q_bit_c = top_c | ~diff_c[W];
            r_nxt_c = q_bit_c ? diff_c[W-1:0] : lo_c;
        end
    end

    // State register with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (k == '0)   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and one quotient bit per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_r         <= '0;
            d_r         <= '0;
            approx_r    <= 1'b0;
            k           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n_r         <= dividend;
                        d_r         <= divisor;
                        approx_r    <= approx_en;
                        k           <= KW'(W - 1);
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= (divisor == '0);
                        overflow    <= (dividend[2*W-1:W] >= divisor);
                    end
                end
                RUN: begin
                    quotient  <= {quotient[W-2:0], q_bit_c};
                    remainder <= r_nxt_c;
                    if (k != '0) k <= k - KW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_approx_divider.sv
// Directed bench for seq_approx_divider: exact/approximate results, flags, latency,
// back-pressure hold and mid-run reset, with a second instance using APPROX_ROWS=0.
module tb_seq_approx_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        approx_en;
    logic        out_ready;

    logic        in_ready,  out_valid,  div_by_zero,  overflow;
    logic [7:0]  quotient,  remainder;
    logic        in_ready0, out_valid0, div_by_zero0, overflow0;
    logic [7:0]  quotient0, remainder0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_approx_divider #(.W(8), .APPROX_ROWS(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    seq_approx_divider #(.W(8), .APPROX_ROWS(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .dividend(dividend), .divisor(divisor), .approx_en(approx_en),
        .out_valid(out_valid0), .out_ready(out_ready), .quotient(quotient0),
        .remainder(remainder0), .div_by_zero(div_by_zero0), .overflow(overflow0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble inputs during RUN, wait for out_valid, check results.
    task automatic do_op(input string tag, input logic [15:0] n, input logic [7:0] d,
                         input logic a, input logic [7:0] eq, input logic [7:0] er,
                         input logic [7:0] eq0, input logic [7:0] er0,
                         input logic edz, input logic eov);
        int lat;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        dividend  = n;
        divisor   = d;
        approx_en = a;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        dividend  = 16'($urandom);
        divisor   = 8'($urandom);
        approx_en = ~a;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"},  64'(lat),          64'd9);
        check({tag, "_q"},        64'(quotient),     64'(eq));
        check({tag, "_r"},        64'(remainder),    64'(er));
        check({tag, "_dz"},       64'(div_by_zero),  64'(edz));
        check({tag, "_ov"},       64'(overflow),     64'(eov));
        check({tag, "_q_ar0"},    64'(quotient0),    64'(eq0));
        check({tag, "_r_ar0"},    64'(remainder0),   64'(er0));
        check({tag, "_valid_ar0"}, 64'(out_valid0),  64'd1);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_rel_ready"}, 64'(in_ready),  64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        approx_en = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready",  64'(in_ready),    64'd1);
        check("rst_out_valid", 64'(out_valid),   64'd0);
        check("rst_q",         64'(quotient),    64'd0);
        check("rst_r",         64'(remainder),   64'd0);
        check("rst_dz",        64'(div_by_zero), 64'd0);
        check("rst_ov",        64'(overflow),    64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("exact_1000_7", 16'd1000, 8'd7, 1'b0, 8'd142, 8'd6, 8'd142, 8'd6, 1'b0, 1'b0);
        release_result("exact_1000_7");

        do_op("approx_1000_7", 16'd1000, 8'd7, 1'b1, 8'd128, 8'd104, 8'd142, 8'd6, 1'b0, 1'b0);
        release_result("approx_1000_7");

        do_op("dz_1234", 16'h1234, 8'd0, 1'b0, 8'hFF, 8'h34, 8'hFF, 8'h34, 1'b1, 1'b1);
        release_result("dz_1234");

        do_op("exact_255_16", 16'd255, 8'd16, 1'b0, 8'd15, 8'd15, 8'd15, 8'd15, 1'b0, 1'b0);
        release_result("exact_255_16");

        do_op("max_q", 16'h7FFF, 8'h80, 1'b0, 8'hFF, 8'h7F, 8'hFF, 8'h7F, 1'b0, 1'b0);
        release_result("max_q");

        // Back-pressure: hold DONE for 5 cycles while a new request is offered.
        do_op("hold", 16'd1000, 8'd7, 1'b0, 8'd142, 8'd6, 8'd142, 8'd6, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            dividend = 16'h0055;
            divisor  = 8'd3;
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_ready", 64'(in_ready),  64'd0);
            check("hold_q",     64'(quotient),  64'd142);
            check("hold_r",     64'(remainder), 64'd6);
        end
        in_valid = 1'b0;
        release_result("hold");
        @(posedge clk); #1;
        check("hold_no_accept", 64'(in_ready), 64'd1);

        // Reset in the 4th RUN cycle aborts the operation.
        in_valid  = 1'b1;
        dividend  = 16'd1000;
        divisor   = 8'd7;
        approx_en = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_q",         64'(quotient),  64'd0);
        check("abort_r",         64'(remainder), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            check("abort_no_result", 64'(out_valid), 64'd0);
        end
        do_op("after_abort", 16'd1000, 8'd7, 1'b0, 8'd142, 8'd6, 8'd142, 8'd6, 1'b0, 1'b0);
        release_result("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_approx_divider.md
SEQ_APPROX_DIVIDER -- requirements
Module: seq_approx_divider

Interface
REQ-001 Parameter W, default 8: divisor, quotient and remainder width; dividend is 2W bits; legal range 2..32.
REQ-002 Parameter APPROX_ROWS, default 6: quotient bits 0..APPROX_ROWS-1 are computed with the approximate cell rule when approx_en=1; legal range 0..W.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 dividend  input  2W  numerator n.
REQ-008 divisor  input  W  denominator d.
REQ-009 approx_en  input  1  1 = approximate low rows; 0 = all rows exact.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 quotient  output  W  quotient q.
REQ-013 remainder  output  W  remainder r.
REQ-014 div_by_zero  output  1  captured d was 0.
REQ-015 overflow  output  1  captured n[2W-1:W] >= d (true quotient exceeds W bits).

Function
REQ-016 The block SHALL be an FSM with states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 In IDLE, in_valid=1 at a rising edge SHALL capture dividend, divisor and approx_en into registers and enter RUN with row index k=W-1; flags are computed from the captured values at that edge.
REQ-018 RUN SHALL resolve one quotient bit per cycle, k = W-1 down to 0, MSB first; after the edge that resolves k=0 the FSM enters DONE; acceptance-to-out_valid latency is exactly W+1 edges (acceptance edge plus W compute edges).
REQ-019 Row window: low part L (W bits) and top bit T; for k=W-1, L=n[2W-2:W-1], T=n[2W-1]; for k<W-1, L={R[W-2:0], n[k]}, T=R[W-1], with R the remainder from row k+1.
REQ-020 Exact row: (B, D) = L - d (W-bit borrow-out B, W-bit difference D); q[k] = T | ~B; R = q[k] ? D : L.
REQ-021 Approximate row (k < APPROX_ROWS and captured approx_en=1): q[k] = T | L[W-1]; R = L; the divisor is not used.
REQ-022 After row 0, quotient = q[W-1:0] and remainder = R.
REQ-023 d=0 SHALL NOT be special-cased: rows follow REQ-020/021 (exact rows yield q[k]=1, R=L); div_by_zero=1 flags it.
REQ-024 Overflow inputs are computed per REQ-019..021 with no saturation; overflow=1 flags them.
REQ-025 In DONE, quotient, remainder and flags SHALL hold stable until out_ready=1 at an edge, which returns the FSM to IDLE; no request is accepted in that same edge.
REQ-026 in_valid while not IDLE SHALL be ignored; inputs changing during RUN SHALL NOT affect the result.
REQ-027 approx_en changing mid-operation SHALL have no effect; only the captured value applies.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, and clear all internal registers.
REQ-029 Reset during RUN or DONE SHALL abort the operation with no result emitted; the first edge after rst deasserts may accept a new request.

Verification (W=8, APPROX_ROWS=6)
REQ-030 approx_en=0, n=1000, d=7 -> out_valid on 9th edge after acceptance, quotient=142, remainder=6, flags 0.
REQ-031 approx_en=1, n=1000, d=7 -> quotient=128, remainder=104, flags 0.
REQ-032 approx_en=0, n=0x1234, d=0 -> quotient=0xFF, remainder=0x34, div_by_zero=1, overflow=1.
REQ-033 out_ready held 0 for 5 cycles after out_valid -> outputs stable, in_ready=0, a new in_valid pulse is ignored; out_ready=1 -> IDLE next edge.
REQ-034 rst pulsed on 4th RUN cycle -> outputs zero immediately, in_ready=1, no out_valid; next request n=1000, d=7, approx_en=0 -> 142/6.
REQ-035 Parameter APPROX_ROWS=0, approx_en=1, n=1000, d=7 -> quotient=142, remainder=6 (identical to exact).
